// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
// Optional glitch filter is selected with PWM_CAPTURE_GLITCH_FILTER_EN (see pwm_sync).
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

    localparam int unsigned DUTY_MAX = 255;

    // Clamp a count to the 8-bit compare range of a 256-clock PWM frame.
    function automatic logic [7:0] sat_duty(input logic [31:0] v);
        return (v > DUTY_MAX) ? 8'(DUTY_MAX) : v[7:0];
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// Input conditioning: synchronizer, optional 3-sample glitch filter, edge detector.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to insert the filter between synchronizer and edge detector.
module pwm_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    // Filtered level only moves once the current sample and the two before it agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            filt_q <= 1'b0;
        end else begin
            hist_q <= {hist_q[0], sync_lvl};
            if ((sync_lvl == hist_q[0]) && (hist_q[0] == hist_q[1])) begin
                filt_q <= sync_lvl;
            end
        end
    end

    assign level = filt_q;
`else
    assign level = sync_lvl;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM decoder: measures high time and period of an asynchronous input, flags stuck levels.
// Build option PWM_CAPTURE_GLITCH_FILTER_EN enables the input glitch filter in pwm_sync.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic [7:0]       duty8,
    output logic             valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic level, rise, fall;

    pwm_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .pwm_in(pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    pwm_state_e       state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [7:0]       duty8_q, duty8_d;
    logic             valid_q, valid_d;
    logic             stuck_hi_q, stuck_hi_d;
    logic             stuck_lo_q, stuck_lo_d;
    logic             timeout;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= TMO) ? TMO : v + ONE;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hi_q        <= '0;
            per_q       <= '0;
            tmo_q       <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            duty8_q     <= '0;
            valid_q     <= 1'b0;
            stuck_hi_q  <= 1'b0;
            stuck_lo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            per_q       <= per_d;
            tmo_q       <= tmo_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            duty8_q     <= duty8_d;
            valid_q     <= valid_d;
            stuck_hi_q  <= stuck_hi_d;
            stuck_lo_q  <= stuck_lo_d;
        end
    end

    // An edge in the same cycle always beats the timeout.
    assign timeout = (tmo_q == TMO) && !rise && !fall;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        per_d       = per_q;
        tmo_d       = (rise || fall) ? ONE : sat_inc(tmo_q);
        high_time_d = high_time_q;
        period_d    = period_q;
        duty8_d     = duty8_q;
        valid_d     = 1'b0;
        stuck_hi_d  = stuck_hi_q;
        stuck_lo_d  = stuck_lo_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                    hi_d    = ONE;
                    per_d   = ONE;
                // Only a low input may be reported stuck low from IDLE.
                end else if (timeout && !stuck_lo_q && !level) begin
                    high_time_d = '0;
                    period_d    = TMO;
                    duty8_d     = 8'd0;
                    stuck_hi_d  = 1'b0;
                    stuck_lo_d  = 1'b1;
                    valid_d     = 1'b1;
                    tmo_d       = '0;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_d = LOW;
                    per_d   = sat_inc(per_q);
                end else if (timeout) begin
                    state_d     = IDLE;
                    high_time_d = TMO;
                    period_d    = TMO;
                    duty8_d     = 8'(DUTY_MAX);
                    stuck_hi_d  = 1'b1;
                    stuck_lo_d  = 1'b0;
                    valid_d     = 1'b1;
                    tmo_d       = '0;
                end else begin
                    hi_d  = sat_inc(hi_q);
                    per_d = sat_inc(per_q);
                end
            end
            LOW: begin
                if (rise) begin
                    state_d     = HIGH;
                    high_time_d = hi_q;
                    period_d    = per_q;
                    duty8_d     = sat_duty(32'(hi_q));
                    stuck_hi_d  = 1'b0;
                    stuck_lo_d  = 1'b0;
                    valid_d     = 1'b1;
                    hi_d        = ONE;
                    per_d       = ONE;
                end else if (timeout) begin
                    state_d     = IDLE;
                    high_time_d = '0;
                    period_d    = TMO;
                    duty8_d     = 8'd0;
                    stuck_hi_d  = 1'b0;
                    stuck_lo_d  = 1'b1;
                    valid_d     = 1'b1;
                    tmo_d       = '0;
                end else begin
                    per_d = sat_inc(per_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign duty8     = duty8_q;
    assign valid     = valid_q;
    assign stuck_hi  = stuck_hi_q;
    assign stuck_lo  = stuck_lo_q;

endmodule
